// File: rtl/apb_bank_arbiter.sv
// apb_bank_arbiter
//   Two-master APB arbiter in front of BANK_NUM GPIO register banks.
//   Master 0 (SPI bridge) and master 1 (autoscan engine) request with psel.
//   IDLE picks one of them (round-robin on a tie), latches the transfer, and
//   runs a SETUP/ACCESS sequence on the selected bank. A bank index outside
//   0..BANK_NUM-1 completes with a one-cycle slave error and no downstream
//   select.
//
// Ports
//   pclk, preset              clock, async active-high reset
//   m0_* / m1_*               APB slave ports facing the two masters
//                             (paddr = {bank[1:0], reg[PADDR_WIDTH-1:0]})
//   s_psel[BANK_NUM-1:0]      one-hot downstream bank select
//   s_penable, s_pwrite,
//   s_paddr, s_pwdata         shared downstream APB controls and data
//   s_pready[BANK_NUM-1:0]    per-bank ready
//   s_prdata                  per-bank read data, bank k at [k*DATA_WIDTH +: DATA_WIDTH]
//
// Build option
//   APB_ARB_TIMEOUT_EN  when defined, an ACCESS phase that sees no pready for
//                       TIMEOUT_CYCLES cycles is abandoned and completed to the
//                       master with pslverr. Undefined: ACCESS waits forever.
module apb_bank_arbiter #(
  parameter int BANK_NUM       = 2,
  parameter int PADDR_WIDTH    = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic                           m0_psel,
  input  logic                           m0_penable,
  input  logic                           m0_pwrite,
  input  logic [PADDR_WIDTH+1:0]         m0_paddr,
  input  logic [DATA_WIDTH-1:0]          m0_pwdata,
  output logic [DATA_WIDTH-1:0]          m0_prdata,
  output logic                           m0_pready,
  output logic                           m0_pslverr,
  input  logic                           m1_psel,
  input  logic                           m1_penable,
  input  logic                           m1_pwrite,
  input  logic [PADDR_WIDTH+1:0]         m1_paddr,
  input  logic [DATA_WIDTH-1:0]          m1_pwdata,
  output logic [DATA_WIDTH-1:0]          m1_prdata,
  output logic                           m1_pready,
  output logic                           m1_pslverr,
  output logic [BANK_NUM-1:0]            s_psel,
  output logic                           s_penable,
  output logic                           s_pwrite,
  output logic [PADDR_WIDTH-1:0]         s_paddr,
  output logic [DATA_WIDTH-1:0]          s_pwdata,
  input  logic [BANK_NUM-1:0]            s_pready,
  input  logic [BANK_NUM*DATA_WIDTH-1:0] s_prdata
);

  localparam int AW = PADDR_WIDTH + 2;
  localparam logic [2:0] BANK_LIM = 3'(BANK_NUM);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

  state_t                  state_q, state_d;
  logic                    gnt_q, gnt_d;     // 0 = m0, 1 = m1
  logic                    last_q, last_d;   // master granted most recently
  logic [AW-1:0]           addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    pick;
  logic [1:0]              req_bank;
  logic [1:0]              bank;
  logic                    sel_ready;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    done;
  logic                    err;

  // penable from the masters carries no information the arbiter needs:
  // a request is psel alone.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  assign bank     = addr_q[AW-1 -: 2];
  assign req_bank = pick ? m1_paddr[AW-1 -: 2] : m0_paddr[AW-1 -: 2];

  // Ready / read data of the bank owned by the current transfer.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < BANK_NUM; k++) begin
      if (bank == 2'(k)) begin
        sel_ready = s_pready[k];
        sel_rdata = s_prdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] to_cnt_q;

  // Held at zero outside ACCESS, so every ACCESS entry starts from zero.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      to_cnt_q <= '0;
    end else if (state_q != ACCESS) begin
      to_cnt_q <= '0;
    end else if (!sel_ready) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end
`else
  // Keeps the timeout parameter referenced when the feature is compiled out.
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;   // m0 wins the first tie after reset
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    // On a tie serve whoever was not granted last; otherwise the sole requester.
    pick    = (m0_psel && m1_psel) ? ~last_q : m1_psel;
    unique case (state_q)
      IDLE: begin
        if (m0_psel || m1_psel) begin
          gnt_d   = pick;
          last_d  = pick;
          addr_d  = pick ? m1_paddr  : m0_paddr;
          write_d = pick ? m1_pwrite : m0_pwrite;
          wdata_d = pick ? m1_pwdata : m0_pwdata;
          state_d = ({1'b0, req_bank} < BANK_LIM) ? SETUP : ERR;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          state_d = IDLE;
`ifdef APB_ARB_TIMEOUT_EN
        end else if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Timeout completion reuses ERR: no select, pready+pslverr to master.
          state_d = ERR;
`endif
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Downstream side: driven only while a bank transfer is in flight.
  always_comb begin
    for (int k = 0; k < BANK_NUM; k++) begin
      s_psel[k] = ((state_q == SETUP) || (state_q == ACCESS)) && (bank == 2'(k));
    end
  end

  assign s_penable = (state_q == ACCESS);
  assign s_pwrite  = (state_q != IDLE) ? write_q : 1'b0;
  assign s_paddr   = (state_q != IDLE) ? addr_q[PADDR_WIDTH-1:0] : '0;
  assign s_pwdata  = (state_q != IDLE) ? wdata_q : '0;

  // Master side: completion goes only to the granted master.
  assign done = (state_q == ACCESS) && sel_ready;
  assign err  = (state_q == ERR);

  assign m0_pready  = !gnt_q && (done || err);
  assign m0_pslverr = !gnt_q && err;
  assign m0_prdata  = (!gnt_q && done) ? sel_rdata : '0;
  assign m1_pready  = gnt_q && (done || err);
  assign m1_pslverr = gnt_q && err;
  assign m1_prdata  = (gnt_q && done) ? sel_rdata : '0;

endmodule

// File: tb/tb_apb_bank_arbiter.sv
module tb_apb_bank_arbiter;
  localparam int BANK_NUM       = 2;
  localparam int PADDR_WIDTH    = 3;
  localparam int DATA_WIDTH     = 8;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int AW             = PADDR_WIDTH + 2;

  logic pclk = 1'b0;
  logic preset;
  logic m0_psel, m0_penable, m0_pwrite, m0_pready, m0_pslverr;
  logic m1_psel, m1_penable, m1_pwrite, m1_pready, m1_pslverr;
  logic [AW-1:0] m0_paddr, m1_paddr;
  logic [DATA_WIDTH-1:0] m0_pwdata, m1_pwdata, m0_prdata, m1_prdata;
  logic [BANK_NUM-1:0] s_psel, s_pready;
  logic s_penable, s_pwrite;
  logic [PADDR_WIDTH-1:0] s_paddr;
  logic [DATA_WIDTH-1:0] s_pwdata;
  logic [BANK_NUM*DATA_WIDTH-1:0] s_prdata;

  // Master-side stimulus, indexed by master number.
  logic [1:0] tb_psel;
  logic [1:0] tb_pwrite;
  logic [1:0][AW-1:0] tb_paddr;
  logic [1:0][DATA_WIDTH-1:0] tb_pwdata;
  logic [1:0] obs_pready, obs_pslverr;
  logic [1:0][DATA_WIDTH-1:0] obs_prdata;

  assign m0_psel = tb_psel[0];   assign m1_psel = tb_psel[1];
  assign m0_penable = tb_psel[0]; assign m1_penable = tb_psel[1];
  assign m0_pwrite = tb_pwrite[0]; assign m1_pwrite = tb_pwrite[1];
  assign m0_paddr = tb_paddr[0]; assign m1_paddr = tb_paddr[1];
  assign m0_pwdata = tb_pwdata[0]; assign m1_pwdata = tb_pwdata[1];
  assign obs_pready  = {m1_pready, m0_pready};
  assign obs_pslverr = {m1_pslverr, m0_pslverr};
  assign obs_prdata  = {m1_prdata, m0_prdata};

  apb_bank_arbiter #(
    .BANK_NUM(BANK_NUM), .PADDR_WIDTH(PADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .pclk(pclk), .preset(preset),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata),
    .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata),
    .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_pready(s_pready), .s_prdata(s_prdata)
  );

  always #5 pclk = ~pclk;

  // Bank models: each bank inserts wait_cfg[k] wait states and returns rd_cfg[k].
  // Unselected banks toggle their pready randomly to expose wrong-bank selection.
  logic [1:0] wait_cfg [BANK_NUM];
  logic [DATA_WIDTH-1:0] rd_cfg [BANK_NUM];
  logic [BANK_NUM-1:0] noise;
  int acc_cnt = 0;

  always @(posedge pclk) begin
    if (s_penable && ((s_psel & s_pready) == '0)) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    s_pready = '0;
    s_prdata = '0;
    for (int k = 0; k < BANK_NUM; k++) begin
      s_pready[k] = noise[k];
      if (s_psel[k]) s_pready[k] = s_penable && (acc_cnt >= int'(wait_cfg[k]));
      s_prdata[k*DATA_WIDTH +: DATA_WIDTH] = rd_cfg[k];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic last_gnt;   // reference model: master granted most recently

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".s_psel"},    32'(s_psel), 0);
    check({tag, ".s_penable"}, 32'(s_penable), 0);
    check({tag, ".s_pwrite"},  32'(s_pwrite), 0);
    check({tag, ".s_paddr"},   32'(s_paddr), 0);
    check({tag, ".s_pwdata"},  32'(s_pwdata), 0);
    check({tag, ".pready"},    32'(obs_pready), 0);
    check({tag, ".pslverr"},   32'(obs_pslverr), 0);
    check({tag, ".prdata"},    32'(obs_prdata), 0);
  endtask

  // One arbitration round: the masters in reqs raise psel together, each
  // holds it until its own completion (the first winner may drop it early).
  // Expected timing comes from the arbitration rules: request seen at cycle 0,
  // winner's SETUP at 1, completion at 1 (bad bank) or 2+waits; the loser is
  // re-arbitrated in the IDLE cycle after that and follows the same rules.
  task automatic run_pair(input logic [1:0] reqs,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic w0, input logic w1,
                          input logic [DATA_WIDTH-1:0] d0, input logic [DATA_WIDTH-1:0] d1,
                          input bit drop);
    logic [AW-1:0] a [2];
    int lat [2], done_c [2], setup_c [2], bnk [2];
    bit ok [2];
    int order [2];
    int nord, start, m;
    a[0] = a0; a[1] = a1;
    for (int i = 0; i < 2; i++) begin
      bnk[i] = int'(a[i][AW-1 -: 2]);
      ok[i]  = bnk[i] < BANK_NUM;
      lat[i] = ok[i] ? 2 + int'(wait_cfg[bnk[i]]) : 1;
      done_c[i] = -1;
      setup_c[i] = -1;
    end
    if (reqs == 2'b11) begin
      order[0] = last_gnt ? 0 : 1;
      order[1] = 1 - order[0];
      nord = 2;
    end else begin
      order[0] = reqs[0] ? 0 : 1;
      order[1] = 0;
      nord = 1;
    end
    start = 0;
    for (int i = 0; i < nord; i++) begin
      m = order[i];
      setup_c[m] = start + 1;
      done_c[m]  = start + lat[m];
      start      = done_c[m] + 1;
      last_gnt   = m[0];
    end

    tb_paddr  = {a1, a0};
    tb_pwrite = {w1, w0};
    tb_pwdata = {d1, d0};
    tb_psel   = reqs;
    #1;
    check("idle.s_psel", 32'(s_psel), 0);
    check("idle.pready", 32'(obs_pready), 0);

    for (int c = 1; c <= start; c++) begin
      @(negedge pclk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("m%0d.pready@%0d", i, c), 32'(obs_pready[i]), 32'(c == done_c[i]));
        if (c == done_c[i]) begin
          check($sformatf("m%0d.pslverr", i), 32'(obs_pslverr[i]), 32'(!ok[i]));
          check($sformatf("m%0d.prdata", i), 32'(obs_prdata[i]),
                ok[i] ? 32'(rd_cfg[bnk[i]]) : 0);
          tb_psel[i] = 1'b0;
        end else begin
          check($sformatf("m%0d.prdata_idle", i), 32'(obs_prdata[i]), 0);
        end
        if (c == setup_c[i]) begin
          if (ok[i]) begin
            check($sformatf("m%0d.setup.s_psel", i), 32'(s_psel), 32'(1) << bnk[i]);
            check($sformatf("m%0d.setup.s_penable", i), 32'(s_penable), 0);
            check($sformatf("m%0d.setup.s_paddr", i), 32'(s_paddr), 32'(a[i][PADDR_WIDTH-1:0]));
            check($sformatf("m%0d.setup.s_pwrite", i), 32'(s_pwrite), 32'(tb_pwrite[i]));
            check($sformatf("m%0d.setup.s_pwdata", i), 32'(s_pwdata), 32'(tb_pwdata[i]));
          end else begin
            check($sformatf("m%0d.err.s_psel", i), 32'(s_psel), 0);
          end
        end
        if (c == setup_c[i] + 1 && ok[i] && c <= done_c[i])
          check($sformatf("m%0d.access.s_penable", i), 32'(s_penable), 1);
      end
      if (drop && c == 1 && lat[order[0]] > 1) tb_psel[order[0]] = 1'b0;
      noise = BANK_NUM'($urandom);
    end
    tb_psel = '0;
  endtask

  task automatic random_round();
    logic [1:0] r;
    for (int k = 0; k < BANK_NUM; k++) begin
      wait_cfg[k] = 2'($urandom_range(0, 3));
      rd_cfg[k]   = DATA_WIDTH'($urandom);
    end
    r = 2'($urandom_range(1, 3));
    run_pair(r, AW'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
             DATA_WIDTH'($urandom), DATA_WIDTH'($urandom), bit'($urandom_range(0, 1)));
  endtask

  initial begin
    preset = 1'b1;
    tb_psel = '0; tb_pwrite = '0; tb_paddr = '0; tb_pwdata = '0;
    noise = '0;
    for (int k = 0; k < BANK_NUM; k++) begin
      wait_cfg[k] = 2'd0;
      rd_cfg[k] = DATA_WIDTH'(8'h11 * (k + 1));
    end
    #3;
    check_all_zero("reset");
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    last_gnt = 1'b1;

    // m0 writes bank 1 reg 2, zero-wait slave.
    run_pair(2'b01, 5'b01_010, 5'b00_000, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0);
    // m1 reads bank 0 reg 3 with two wait states.
    wait_cfg[0] = 2'd2; rd_cfg[0] = 8'h3C;
    run_pair(2'b10, 5'b00_000, 5'b00_011, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    // Bank index beyond BANK_NUM.
    run_pair(2'b01, 5'b11_000, 5'b00_000, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b0);
    // Repeated ties alternate.
    run_pair(2'b11, 5'b00_001, 5'b01_110, 1'b1, 1'b0, 8'h12, 8'h34, 1'b0);
    run_pair(2'b11, 5'b01_001, 5'b00_110, 1'b0, 1'b1, 8'h56, 8'h78, 1'b0);

    repeat (40) random_round();

    // Reset in the middle of ACCESS abandons the transfer.
    noise = '0;
    wait_cfg[0] = 2'd3;
    tb_paddr = {5'b00_000, 5'b00_101};
    tb_pwrite = 2'b00;
    tb_psel = 2'b01;
    @(negedge pclk);
    @(negedge pclk);
    check("rst_mid.access", 32'(s_penable), 1);
    #1 preset = 1'b1;
    #1;
    check_all_zero("rst_mid.async");
    tb_psel = '0;
    @(negedge pclk);
    check_all_zero("rst_mid.held");
    preset = 1'b0;
    last_gnt = 1'b1;
    wait_cfg[0] = 2'd0;
    run_pair(2'b11, 5'b00_010, 5'b01_011, 1'b0, 1'b1, 8'h9A, 8'hBC, 1'b0);

    repeat (20) random_round();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
